// File: rtl/dnn_accel_pkg.sv
// dnn_accel_pkg: shared encodings and constants for the psum read-back path
package dnn_accel_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} rd_state_e;
  localparam int CTRL_START = 2;
  localparam int CTRL_ABORT = 3;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_WORDS_LSB = 16;
  localparam int PSUM_FIFO_DEPTH = 4;
  localparam int PSUM_FIFO_AW = $clog2(PSUM_FIFO_DEPTH);
  typedef logic [PSUM_FIFO_AW-1:0] fifo_ptr_t;
  typedef logic [PSUM_FIFO_AW:0] fifo_occ_t;
endpackage

// File: rtl/psum_rd_fifo.sv
// psum_rd_fifo: small register-array FIFO carrying read data plus a per-entry last flag
module psum_rd_fifo
  import dnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output fifo_occ_t             occupancy,
  output logic                  empty
);
  logic [PSUM_FIFO_DEPTH-1:0][DATA_WIDTH:0] mem;
  fifo_ptr_t wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = occupancy == '0;
  assign do_push = push && occupancy != fifo_occ_t'(PSUM_FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign o_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign o_last = !empty && mem[rd_ptr][DATA_WIDTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr <= wr_ptr + fifo_ptr_t'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + fifo_ptr_t'(1);
      occupancy <= occupancy + fifo_occ_t'(do_push) - fifo_occ_t'(do_pop);
    end
endmodule

// File: rtl/psum_bram_reader.sv
// psum_bram_reader: streams a configured range of psum BRAM words out over valid/ready
module psum_bram_reader
  import dnn_accel_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_INCR  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_rdbase,
  input  logic [REG_WIDTH-1:0]  i_conf_rdcount,
  output logic [REG_WIDTH-1:0]  o_conf_status,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);
  rd_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0] cnt_q, k_q;
  logic [15:0] words_q;
  logic start_prev, inflight_q, last_q, busy_q, done_q;
  logic start_edge, abort, can_issue, issue, is_final, hs, go;
  fifo_occ_t occ;
  logic fifo_empty;
  logic unused_bits;
  assign unused_bits = ^{i_conf_ctrl, i_conf_rdbase};
  assign start_edge = i_conf_ctrl[CTRL_START] && !start_prev;
  assign abort = i_conf_ctrl[CTRL_ABORT];
  assign go = state == ST_IDLE && start_edge && !abort;
  // No credit for a same-cycle pop: the returning word needs a guaranteed slot
  assign can_issue = (4'(occ) + 4'(inflight_q)) < 4'(PSUM_FIFO_DEPTH);
  assign issue = state == ST_READ && !abort && can_issue;
  assign is_final = k_q == cnt_q;
  assign hs = o_valid && i_ready;
  assign o_valid = !fifo_empty;
  assign mem_idat = '0;
  assign mem_wren = '0;
  assign mem_rst = 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = go ? ST_READ : ST_IDLE;
      ST_READ:  state_nxt = abort ? ST_IDLE : (issue && is_final) ? ST_DRAIN : ST_READ;
      ST_DRAIN: state_nxt = (abort || (hs && o_last)) ? ST_IDLE : ST_DRAIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    mem_enb = issue;
    mem_addr = state == ST_READ ? addr_q : '0;
    o_conf_status = '0;
    o_conf_status[STAT_BUSY] = busy_q;
    o_conf_status[STAT_DONE] = done_q;
    o_conf_status[STAT_WORDS_LSB +: 16] = words_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      words_q <= '0;
      start_prev <= 1'b0;
      inflight_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      start_prev <= i_conf_ctrl[CTRL_START];
      inflight_q <= issue;
      last_q <= issue && is_final;
      if (go) begin
        addr_q <= i_conf_rdbase[ADDR_WIDTH-1:0];
        cnt_q <= i_conf_rdcount;
        k_q <= '0;
        words_q <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + ADDR_WIDTH'(ADDR_INCR);
          k_q <= k_q + REG_WIDTH'(1);
        end
        if (hs) words_q <= words_q + 16'd1;
        if (abort) begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end else if (state == ST_DRAIN && hs && o_last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  // An abort drops both the queued words and the read still returning from the BRAM
  psum_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q && !abort),
    .push_data (mem_odat),
    .push_last (last_q),
    .pop       (i_ready),
    .flush     (abort),
    .o_data    (o_data),
    .o_last    (o_last),
    .occupancy (occ),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_psum_bram_reader.sv
// tb_psum_bram_reader: directed bench with a word-sequence model and per-cycle compare
module tb_psum_bram_reader;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] i_conf_ctrl = '0, i_conf_rdbase = '0, i_conf_rdcount = '0;
  logic [31:0] o_conf_status, mem_addr, mem_idat, mem_odat = '0, o_data;
  logic [3:0] mem_wren;
  logic mem_enb, mem_rst, o_valid, o_last, i_ready = 1'b0;
  logic [31:0] s8, idat8, odat8 = '0, d8;
  logic [7:0] a8;
  logic [3:0] wren8;
  logic enb8, rst8, v8, l8;

  psum_bram_reader dut (
    .clk(clk), .rst(rst), .i_conf_ctrl(i_conf_ctrl), .i_conf_rdbase(i_conf_rdbase),
    .i_conf_rdcount(i_conf_rdcount), .o_conf_status(o_conf_status), .mem_addr(mem_addr),
    .mem_idat(mem_idat), .mem_odat(mem_odat), .mem_wren(mem_wren), .mem_enb(mem_enb),
    .mem_rst(mem_rst), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last)
  );
  psum_bram_reader #(.ADDR_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .i_conf_ctrl(i_conf_ctrl), .i_conf_rdbase(i_conf_rdbase),
    .i_conf_rdcount(i_conf_rdcount), .o_conf_status(s8), .mem_addr(a8),
    .mem_idat(idat8), .mem_odat(odat8), .mem_wren(wren8), .mem_enb(enb8),
    .mem_rst(rst8), .o_data(d8), .o_valid(v8), .i_ready(i_ready), .o_last(l8)
  );

  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  int n_enb = 0, n_hs = 0, rise_cyc = 0, last_hs = 0, flush_cnt = 0, seen_flush = 0;
  logic [31:0] exp_word[$], exp_addr[$];
  bit exp_lst[$];
  logic [7:0] a8_q[$];
  logic [31:0] prev_data, rise_data, last_data;
  bit prev_stall = 0, prev_last = 0, prev_valid = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (mem_enb) mem_odat <= data_of(mem_addr);
  end

  always @(negedge clk) begin
    if (flush_cnt != seen_flush) begin
      seen_flush = flush_cnt;
      exp_word.delete();
      exp_addr.delete();
      exp_lst.delete();
      n_enb = n_hs;
      prev_stall = 0;
    end
    if (rst) begin
      if (enb8) a8_q.push_back(a8);
      if (mem_enb) begin
        n_enb++;
        if (exp_addr.size() == 0) chk("unexpected_read", mem_addr, 32'hxxxx_xxxx);
        else chk("rd_addr", mem_addr, exp_addr.pop_front());
      end
      chk("outstanding_le4", 32'(n_enb - n_hs <= 4), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", o_data, prev_data);
        chk("stall_last", 32'(o_last), 32'(prev_last));
      end
      if (o_valid) begin
        chk("valid_expected", 32'(exp_word.size() != 0), 32'd1);
        if (!prev_valid) begin
          rise_cyc = cyc;
          rise_data = o_data;
        end
        if (i_ready && exp_word.size() != 0) begin
          chk("word_data", o_data, exp_word.pop_front());
          chk("word_last", 32'(o_last), 32'(exp_lst.pop_front()));
          n_hs++;
          last_hs = cyc;
          last_data = o_data;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_valid = o_valid;
      prev_data = o_data;
      prev_last = o_last;
    end else begin
      prev_stall = 0;
      prev_valid = 0;
    end
  end

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] cnt);
    @(posedge clk); #1;
    i_conf_rdbase = base;
    i_conf_rdcount = cnt;
    i_conf_ctrl = 32'h4;
    t0 = cyc;
    for (int k = 0; k <= int'(cnt); k++) begin
      exp_addr.push_back(base + 32'(k * 4));
      exp_word.push_back(data_of(base + 32'(k * 4)));
      exp_lst.push_back(k == int'(cnt));
    end
    @(posedge clk); #1;
    i_conf_ctrl = '0;
  endtask

  // mode 0: ready high, 1: toggle every cycle, 2: random stalls
  task automatic run(input int mode, input int budget);
    int n = 0;
    forever begin
      i_ready = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      n++;
      if (exp_word.size() == 0 || n >= budget) break;
      @(posedge clk); #1;
    end
    chk("xfer_complete_words_left", 32'(exp_word.size()), 32'd0);
  endtask

  task automatic fin(input string nm, input logic [31:0] st);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk(nm, o_conf_status, st);
  endtask

  initial begin
    int hs0;
    #2;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_data", o_data, 32'd0);
    chk("reset_enb", 32'(mem_enb), 32'd0);
    chk("reset_status", o_conf_status, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    // basic
    start_xfer(32'h100, 32'd7);
    run(0, 100);
    chk("basic_valid_latency", 32'(rise_cyc - t0), 32'd3);
    chk("basic_last_hs_cycle", 32'(last_hs - t0), 32'd10);
    chk("basic_first_word", rise_data, 32'hA5A5_0100);
    chk("basic_last_word", last_data, 32'hA5A5_011C);
    chk("basic_status_at_last_hs", o_conf_status, 32'h0007_0001);
    fin("basic_status", 32'h0008_0002);
    // backpressure
    start_xfer(32'h1000, 32'd63);
    run(2, 1000);
    fin("random_stall_status", 32'h0040_0002);
    start_xfer(32'h2000, 32'd15);
    run(1, 200);
    fin("toggle_stall_status", 32'h0010_0002);
    // single word
    start_xfer(32'h40, 32'd0);
    run(0, 20);
    chk("single_word", last_data, 32'hA5A5_0040);
    fin("single_status", 32'h0001_0002);
    // address wrap
    a8_q.delete();
    start_xfer(32'hFFFF_FFF8, 32'd3);
    run(0, 50);
    fin("wrap_status", 32'h0004_0002);
    chk("wrap8_count", 32'(a8_q.size()), 32'd4);
    if (a8_q.size() == 4) begin
      chk("wrap8_a0", 32'(a8_q[0]), 32'h0000_00F8);
      chk("wrap8_a1", 32'(a8_q[1]), 32'h0000_00FC);
      chk("wrap8_a2", 32'(a8_q[2]), 32'h0000_0000);
      chk("wrap8_a3", 32'(a8_q[3]), 32'h0000_0004);
    end
    // abort after 5 of 32 words, sink stalled
    hs0 = n_hs;
    start_xfer(32'h200, 32'd31);
    for (int c = 0; c < 12; c++) begin
      i_ready = (n_hs - hs0) < 5;
      @(posedge clk); #1;
    end
    i_ready = 1'b0;
    chk("abort_valid_before", 32'(o_valid), 32'd1);
    i_conf_ctrl = 32'h8;
    @(posedge clk); #1;
    i_conf_ctrl = '0;
    flush_cnt++;
    chk("abort_valid_next", 32'(o_valid), 32'd0);
    chk("abort_status", o_conf_status, 32'h0005_0000);
    chk("abort_delivered", 32'(n_hs - hs0), 32'd5);
    start_xfer(32'h200, 32'd3);
    run(0, 50);
    chk("restart_first_word", rise_data, 32'hA5A5_0200);
    fin("restart_status", 32'h0004_0002);
    // abort in idle clears done; start together with abort is ignored
    @(posedge clk); #1;
    i_conf_ctrl = 32'h8;
    @(posedge clk); #1;
    i_conf_ctrl = '0;
    @(negedge clk); #1;
    chk("idle_abort_status", o_conf_status, 32'h0004_0000);
    @(posedge clk); #1;
    i_conf_ctrl = 32'hC;
    @(posedge clk); #1;
    i_conf_ctrl = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("start_abort_status", o_conf_status, 32'h0004_0000);
    // reset mid-transfer
    start_xfer(32'h300, 32'd15);
    repeat (6) begin
      i_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    flush_cnt++;
    #1;
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_last", 32'(o_last), 32'd0);
    chk("rst_mid_data", o_data, 32'd0);
    chk("rst_mid_enb", 32'(mem_enb), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_status", o_conf_status, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_status", o_conf_status, 32'd0);
    // second start while busy is ignored
    start_xfer(32'h400, 32'd9);
    i_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_conf_rdbase = 32'h500;
    i_conf_ctrl = 32'h4;
    @(posedge clk); #1;
    i_conf_ctrl = '0;
    run(0, 60);
    fin("busy_restart_ignored_status", 32'h000A_0002);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/psum_bram_reader.md
# psum_bram_reader

Read-back engine for the partial-sum BRAM: once the accelerator core has written its output psums, this block reads a configured range of words from the BRAM port the core used for writing. It streams them out over a valid/ready interface with a last-word marker, toward a DMA or host-side sink. It is the reader counterpart of the core's psum write path and sits beside `psum_bramctrl_bus_mux`, driving the same `mem_*` port bundle.

## Interface

Parameters:
- `ADDR_WIDTH`, 32: BRAM address width.
- `DATA_WIDTH`, 32: BRAM / stream data width.
- `NUM_BYTE`, 4: write-enable width.
- `REG_WIDTH`, 32: config register width.
- `ADDR_INCR`, 4: address step per word, in bytes.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `i_conf_ctrl`, in, REG_WIDTH: bit2 = start (rising edge), bit3 = abort (level); other bits ignored.
- `i_conf_rdbase`, in, REG_WIDTH: first read address; low ADDR_WIDTH bits used.
- `i_conf_rdcount`, in, REG_WIDTH: word count minus 1.
- `o_conf_status`, out, REG_WIDTH: bit0 = busy, bit1 = done (sticky), [31:16] = words delivered, low 16 bits.
- `mem_addr`, out, ADDR_WIDTH: BRAM address.
- `mem_idat`, out, DATA_WIDTH: tied 0.
- `mem_odat`, in, DATA_WIDTH: BRAM read data, 1-cycle latency.
- `mem_wren`, out, NUM_BYTE: tied 0.
- `mem_enb`, out, 1: read enable.
- `mem_rst`, out, 1: tied 0.
- `o_data`, out, DATA_WIDTH: stream data.
- `o_valid`, out, 1: stream valid.
- `i_ready`, in, 1: stream ready.
- `o_last`, out, 1: marks the final word of a transfer.

## Operation

- **FSM states:** IDLE, READ, DRAIN.
- **IDLE → READ:** on a start rising edge (bit2 high now, low in the previous cycle) with abort low.
  - Latch base and count.
  - Clear done and the word counter.
  - Set busy.
- **Start while busy:** ignored.
- **READ, issuing:** `mem_enb`=1 at `mem_addr` = base + k·ADDR_INCR, k = 0..count.
  - A read is issued only when FIFO occupancy + in-flight < 4.
  - Same-cycle pop credit is not used.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- **READ, capture:** the word returned one cycle after `mem_enb` is pushed into the 4-entry FIFO.
- **READ → DRAIN:** after the read with k = count is issued.
- **DRAIN → IDLE:** when the FIFO is empty and nothing is in flight, after the final handshake.
  - Set done; clear busy.
- **Handshake:** a word transfers when `o_valid` && `i_ready`.
  - `o_data`/`o_last` stay stable while `o_valid` && !`i_ready`.
  - `o_last`=1 only on word index = count.
- **Word counter:** increments per handshake, truncated to 16 bits in status.
- **Abort (bit3 high) in READ/DRAIN:**
  - Stop issuing reads.
  - Flush the FIFO; discard the in-flight return.
  - Deassert `o_valid` next cycle.
  - Go to IDLE with done=0, busy=0.
- **Abort in IDLE:** clears done.
- **Start and abort high in the same cycle:** abort wins; no start.
- **rdcount=0:** exactly one word, with `o_last`=1.

## Timing

- **Reset (`rst` low, async):**
  - State IDLE; FIFO empty.
  - `o_valid`=0, `o_last`=0, `o_data`=0.
  - `mem_enb`=0, `mem_addr`=0.
  - `o_conf_status`=0.
- **Reset mid-transfer:** same values immediately; no word is delivered after release until a new start.
- **Latency:**
  - Start edge sampled at cycle 0.
  - First `mem_enb` at cycle 1.
  - FIFO push at cycle 2.
  - `o_valid` at cycle 3, because the FIFO output is registered.
- **Throughput:** with `i_ready` held high, one word per cycle sustained. An N-word transfer completes its last handshake at cycle N+2.
- **Done timing:** done/busy update one cycle after the last handshake.

## Structure

- **Shared package `dnn_accel_pkg`:**
  - FSM state encodings.
  - `i_conf_ctrl` bit indices (START=2, ABORT=3).
  - Status bit indices.
  - FIFO depth constant (4).
- **Sub-module `psum_rd_fifo`:**
  - 4-entry synchronous FIFO with registered output.
  - Ports: push, pop, flush, occupancy, empty.
  - `o_last` is stored per entry.
- **Top:** FSM, address/issue counter, in-flight flag, status register.

## Test plan

- **Basic:** base=0x100, rdcount=7, `i_ready`=1 → 8 words from 0x100..0x11C in order; `o_valid` at cycle 3; `o_last` on word 8; status = 0x0008_0002.
- **Backpressure:** `i_ready` toggled every other cycle; random stalls over 64 words.
  - No loss or duplicates.
  - `o_data` stable under stall.
  - At most 4 outstanding words (occupancy + in-flight).
- **Single word:** rdcount=0 → one word with `o_last`=1; done set.
- **Address wrap:** ADDR_WIDTH=8, base=0xF8, rdcount=3 → addresses 0xF8, 0xFC, 0x00, 0x04.
- **Abort:** abort after 5 of 32 words with `i_ready`=0.
  - `o_valid` low the next cycle.
  - status = busy 0, done 0.
  - A restart delivers from base again.
- **Reset:** assert `rst` low mid-transfer → outputs go to reset values asynchronously; a second start edge during busy is ignored.
